// File: rtl/req_encoder8_hs.sv
// Sequential 8-to-3 request encoder: sticky pending capture, one binary code per valid/ready handshake.
// Define REQ_ENC_ROUND_ROBIN_EN for round-robin selection; default is fixed lowest-index priority.
module req_encoder8_hs #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  req,
  input  logic              hold,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic [WIDTH-1:0]  pending,
  output logic [3:0]        pend_cnt,
  output logic              overrun
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [WIDTH-1:0]    pend_q, pend_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ovr_q, ovr_d;
  logic [WIDTH-1:0]    clr;
  logic                handshake;
  logic                sel_found;
  logic [CODE_W-1:0]   sel_idx;
`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0]   last_q, last_d;
  logic [CODE_W-1:0]   probe;
`endif

  assign handshake = (state_q == PRESENT) && out_ready;

  // Requests set pending bits after the completed code is cleared, so a same-cycle set wins.
  always_comb begin
    clr = '0;
    if (handshake) clr[code_q] = 1'b1;
    pend_d = (pend_q & ~clr) | req;
    ovr_d  = |(req & pend_q & ~clr);
    cnt_d  = '0;
    for (int i = 0; i < WIDTH; i++) cnt_d = cnt_d + 4'(pend_d[i]);
  end

`ifdef REQ_ENC_ROUND_ROBIN_EN
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int i = 1; i <= WIDTH; i++) begin
      probe = last_q + CODE_W'(i);
      if (!sel_found && pend_q[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
  end
`else
  always_comb begin
    sel_found = |pend_q;
    sel_idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = CODE_W'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (!hold && sel_found) begin
          state_d = PRESENT;
          code_d  = sel_idx;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef REQ_ENC_ROUND_ROBIN_EN
          last_d  = code_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef REQ_ENC_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= '1;
    else        last_q <= last_d;
  end
`endif

  assign out_valid = (state_q == PRESENT);
  assign out_code  = code_q;
  assign pending   = pend_q;
  assign pend_cnt  = cnt_q;
  assign overrun   = ovr_q;

endmodule

// File: doc/req_encoder8_hs.md
Name: req_encoder8_hs

Overview:
- Sequential 8-to-3 encoder: the inverse of the 3-to-8 one-hot decoder used in the design.
- Captures up to 8 request lines into a sticky pending register. Presents one request at a time as a 3-bit binary code, via a valid/ready handshake.
- Sits between scattered request sources (event/interrupt-style pulses) and a consumer that handles one coded event at a time.

Parameters:
- WIDTH, 8, number of request lines; fixed at 8 for this block.
- CODE_W, 3, code width; must satisfy 2**CODE_W == WIDTH.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  WIDTH  request lines; any bit high for a cycle sets its pending bit
- hold  input  1  high = do not start presenting a new code; pending capture continues
- out_ready  input  1  consumer accepts the presented code
- out_valid  output  1  out_code is valid
- out_code  output  CODE_W  binary index of the presented request
- pending  output  WIDTH  current sticky pending vector (registered)
- pend_cnt  output  4  number of set bits in pending, 0..8
- overrun  output  1  one-cycle pulse: a req bit arrived while that bit was already pending

Behaviour:
- Reset (rst_n low, async): pending=0, pend_cnt=0, out_valid=0, out_code=0, overrun=0, FSM=IDLE.
- Pending update every cycle: pending <= (pending & ~clr) | req.
  - clr is the one-hot of out_code in the cycle a handshake completes (out_valid & out_ready), else 0.
  - Set wins: a req on the bit being cleared in the same cycle leaves it pending.
- pend_cnt is a registered popcount of the next pending value, so it always matches the pending output.
- overrun <= |(req & pending & ~clr); it asserts the cycle after the offending req. Requests are never queued deeper than one per bit.
- FSM has two states.
  - IDLE:
    - out_valid=0.
    - If hold=0 and pending!=0: out_code <= selected index, out_valid <= 1, go PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT:
    - out_valid=1 and out_code held stable until accepted.
    - hold does not retract a presented code.
    - When out_ready=1: handshake completes, pending bit out_code clears (subject to set-wins), out_valid <= 0, go IDLE.
- Selection uses the registered pending, not raw req. Default is fixed priority: lowest index wins (bit 0 highest).
- Latency:
  - req at edge n → pending at n+1 → out_valid at n+2 (if IDLE, hold=0).
  - Back-to-back throughput is one code per 2 cycles: accept at edge k, next valid at k+2.
- out_ready while out_valid=0 is ignored.
- All 8 pending: drained in priority order, 8 handshakes; pend_cnt counts 8→0.
- Async reset mid-PRESENT drops the presented code and all pending immediately. No handshake is completed.

Optional Feature:
- Macro: REQ_ENC_ROUND_ROBIN_EN.
- Defined:
  - Adds a registered last_code (reset 7). Selection searches from (last_code+1) mod 8 upward, wrapping 7→0.
  - last_code <= out_code on each completed handshake.
  - Gives fair service under continuous requests.
- Undefined: fixed lowest-index priority; no last_code register.
- Ports and timing are identical in both builds.

Test Plan:
- Reset with req=8'hFF held → all outputs 0 while rst_n=0. After release: pending=8'hFF at next edge, pend_cnt=8, out_valid at the following edge with out_code=0.
- Single pulse req=8'h20, out_ready=1 constantly → out_valid high for exactly 1 cycle with out_code=5 two cycles after the pulse. Pending then returns to 0 and overrun stays 0.
- req=8'h0A, out_ready=1 → fixed-priority build gives codes 1 then 3, spaced 2 cycles apart. Round-robin build after a prior code 2 gives 3 then 1.
- Presented code 4 with out_ready=0 for 5 cycles, hold pulsed high, req=8'h01 arriving meanwhile → out_code stays 4, out_valid stays 1. After accept, the next code is 0.
- req bit 6 pulsed twice while pending[6]=1 → overrun pulses twice and pend_cnt is unchanged. req bit 6 asserted in the same cycle as its handshake → pending[6] remains 1 and code 6 is presented again.
- Assert rst_n=0 asynchronously mid-PRESENT with pending=8'h81 → out_valid, pending and pend_cnt go 0 without waiting for a clock edge.
